// File: rtl/gumnut_fetch.sv
// gumnut_fetch -- instruction fetch stage for the Gumnut core.
//
// Keeps the program counter, runs Wishbone-style read cycles on the
// instruction port, and registers each returned word for the decoder
// behind a valid/ready handshake. Control-flow redirects replace the PC
// and any fetch already in flight for the old path is discarded.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : bus cycles that see no ack for TIMEOUT_CYCLES cycles are
//               abandoned, err_o pulses once and the fetch is retried.
//   undefined : the bus waits for ack indefinitely and err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   inst_cyc_o/stb_o   Wishbone cycle/strobe (stb is a copy of cyc)
//   inst_adr_o         fetch address (the PC)
//   inst_ack_i         memory acknowledge
//   inst_dat_i         read data, valid with ack
//   inst_o, pc_o       registered instruction and its address
//   valid_o, ready_i   decoder handshake
//   redirect_i         one-cycle request to fetch from redirect_addr_i
//   redirect_addr_i    redirect target
//   err_o              one-cycle fetch timeout pulse
module gumnut_fetch #(
    parameter int unsigned       ADDR_W         = 12,
    parameter int unsigned       INST_W         = 18,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              inst_cyc_o,
    output logic              inst_stb_o,
    output logic [ADDR_W-1:0] inst_adr_o,
    input  logic              inst_ack_i,
    input  logic [INST_W-1:0] inst_dat_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              stale;   // current bus cycle belongs to a redirected-away path
    logic              cyc;
    logic              timeout;

    assign inst_cyc_o = cyc;
    assign inst_stb_o = cyc;
    // The PC register drives the bus address directly, so a redirect during
    // a bus cycle shows the new target on adr while the old cycle completes.
    assign inst_adr_o = pc;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err_q;

    // wait_cnt counts completed BUS cycles without ack; the comparison fires
    // in the TIMEOUT_CYCLES-th BUS cycle so cyc is high exactly that long.
    assign timeout = (wait_cnt == 4'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == S_BUS) && !inst_ack_i && timeout;
            if (state != S_BUS || inst_ack_i || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            stale   <= 1'b0;
            cyc     <= 1'b0;
            inst_o  <= '0;
            pc_o    <= '0;
            valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_i)
                        pc <= redirect_addr_i;
                    cyc   <= 1'b1;
                    state <= S_BUS;
                end

                S_BUS: begin
                    if (inst_ack_i) begin
                        cyc   <= 1'b0;
                        stale <= 1'b0;
                        if (redirect_i) begin
                            // Data for the old path is dropped; refetch at target.
                            pc    <= redirect_addr_i;
                            state <= S_IDLE;
                        end else if (stale) begin
                            // PC already holds the redirect target.
                            state <= S_IDLE;
                        end else begin
                            inst_o  <= inst_dat_i;
                            pc_o    <= pc;
                            pc      <= pc + ADDR_W'(1);
                            valid_o <= 1'b1;
                            state   <= S_HOLD;
                        end
                    end else if (timeout) begin
                        // Abandon the cycle and retry at the current PC.
                        cyc   <= 1'b0;
                        stale <= 1'b0;
                        if (redirect_i)
                            pc <= redirect_addr_i;
                        state <= S_IDLE;
                    end else if (redirect_i) begin
                        // Let the in-flight cycle finish, but mark its data stale.
                        pc    <= redirect_addr_i;
                        stale <= 1'b1;
                    end
                end

                S_HOLD: begin
                    // Redirect takes priority over a consume; both start a new fetch.
                    if (redirect_i || ready_i) begin
                        if (redirect_i)
                            pc <= redirect_addr_i;
                        valid_o <= 1'b0;
                        cyc     <= 1'b1;
                        state   <= S_BUS;
                    end
                end

                default: begin
                    cyc     <= 1'b0;
                    valid_o <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gumnut_fetch.sv
// Directed testbench for gumnut_fetch. A behavioural instruction memory
// returns word 18'h0A5A5 ^ adr after a programmable number of wait states.
module tb_gumnut_fetch;

    logic        clk;
    logic        rst;
    logic        cyc, stb, ack;
    logic [11:0] adr;
    logic [17:0] dat;
    logic [17:0] inst;
    logic [11:0] pc;
    logic        valid, ready, redirect, err;
    logic [11:0] redirect_addr;

    int total = 0;
    int bad   = 0;

    int unsigned ws       = 0;  // memory wait states
    int unsigned mem_cnt  = 0;
    logic        mem_hold = 1'b0;

    gumnut_fetch #(
        .ADDR_W(12),
        .INST_W(18),
        .RESET_PC(12'h000),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .inst_cyc_o(cyc),
        .inst_stb_o(stb),
        .inst_adr_o(adr),
        .inst_ack_i(ack),
        .inst_dat_i(dat),
        .inst_o(inst),
        .pc_o(pc),
        .valid_o(valid),
        .ready_i(ready),
        .redirect_i(redirect),
        .redirect_addr_i(redirect_addr),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: updates ack/data mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (cyc && !mem_hold) begin
            if (mem_cnt >= ws) begin
                ack     = 1'b1;
                dat     = 18'h0A5A5 ^ {6'h00, adr};
                mem_cnt = 0;
            end else begin
                ack     = 1'b0;
                mem_cnt = mem_cnt + 1;
            end
        end else begin
            ack     = 1'b0;
            mem_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total++; if (cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b want=0", cyc); end
        total++; if (stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b want=0", stb); end
        total++; if (adr !== 12'h000) begin bad++; $display("FAIL rst_adr got=%h want=000", adr); end
        total++; if (inst !== 18'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", inst); end
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL rst_pc got=%h want=000", pc); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        ready = 1'b1;
        tick();
        total++; if (cyc !== 1'b1 || stb !== 1'b1) begin bad++; $display("FAIL ff_cyc got=%b/%b want=1/1", cyc, stb); end
        total++; if (adr !== 12'h000) begin bad++; $display("FAIL ff_adr got=%h want=000", adr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ff_valid_early got=%b want=0", valid); end
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL ff_valid got=%b want=1", valid); end
        total++; if (inst !== 18'h0A5A5) begin bad++; $display("FAIL ff_inst got=%h want=0a5a5", inst); end
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL ff_pc got=%h want=000", pc); end
        total++; if (cyc !== 1'b0) begin bad++; $display("FAIL ff_cyc_hold got=%b want=0", cyc); end
        total++; if (adr !== 12'h001) begin bad++; $display("FAIL ff_next_adr got=%h want=001", adr); end
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h001) begin bad++; $display("FAIL ff_fetch1 got cyc=%b adr=%h want cyc=1 adr=001", cyc, adr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ff_consumed got=%b want=0", valid); end
        tick();
        total++; if (valid !== 1'b1 || inst !== 18'h0A5A4 || pc !== 12'h001) begin bad++; $display("FAIL ff_inst1 got v=%b i=%h p=%h want v=1 i=0a5a4 p=001", valid, inst, pc); end
    endtask

    task automatic test_ready_stall();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (valid !== 1'b1 || inst !== 18'h0A5A4 || pc !== 12'h001) begin bad++; $display("FAIL stall_hold%0d got v=%b i=%h p=%h want v=1 i=0a5a4 p=001", i, valid, inst, pc); end
            total++; if (cyc !== 1'b0) begin bad++; $display("FAIL stall_cyc%0d got=%b want=0", i, cyc); end
        end
        ready = 1'b1;
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h002 || valid !== 1'b0) begin bad++; $display("FAIL stall_resume got cyc=%b adr=%h v=%b want 1/002/0", cyc, adr, valid); end
        tick();
        total++; if (valid !== 1'b1 || inst !== 18'h0A5A7 || pc !== 12'h002) begin bad++; $display("FAIL stall_inst2 got v=%b i=%h p=%h want 1/0a5a7/002", valid, inst, pc); end
    endtask

    task automatic test_redirect_bus();
        tick();
        tick();
        total++; if (valid !== 1'b1 || inst !== 18'h0A5A6 || pc !== 12'h003) begin bad++; $display("FAIL rb_inst3 got v=%b i=%h p=%h want 1/0a5a6/003", valid, inst, pc); end
        ws = 3;
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h004) begin bad++; $display("FAIL rb_bus4 got cyc=%b adr=%h want 1/004", cyc, adr); end
        redirect      = 1'b1;
        redirect_addr = 12'h123;
        tick();
        redirect = 1'b0;
        total++; if (cyc !== 1'b1 || adr !== 12'h123) begin bad++; $display("FAIL rb_pending got cyc=%b adr=%h want 1/123", cyc, adr); end
        tick();
        tick();
        total++; if (cyc !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL rb_wait got cyc=%b v=%b want 1/0", cyc, valid); end
        tick();
        total++; if (cyc !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL rb_stale_drop got cyc=%b v=%b want 0/0", cyc, valid); end
        ws = 0;
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h123 || valid !== 1'b0) begin bad++; $display("FAIL rb_refetch got cyc=%b adr=%h v=%b want 1/123/0", cyc, adr, valid); end
        tick();
        total++; if (valid !== 1'b1 || inst !== 18'h0A486 || pc !== 12'h123) begin bad++; $display("FAIL rb_target got v=%b i=%h p=%h want 1/0a486/123", valid, inst, pc); end
    endtask

    task automatic test_redirect_hold_wrap();
        redirect      = 1'b1;
        redirect_addr = 12'hFFF;
        tick();
        redirect = 1'b0;
        total++; if (valid !== 1'b0 || cyc !== 1'b1 || adr !== 12'hFFF) begin bad++; $display("FAIL rh_drop got v=%b cyc=%b adr=%h want 0/1/fff", valid, cyc, adr); end
        tick();
        total++; if (valid !== 1'b1 || inst !== 18'h0AA5A || pc !== 12'hFFF) begin bad++; $display("FAIL rh_target got v=%b i=%h p=%h want 1/0aa5a/fff", valid, inst, pc); end
        total++; if (adr !== 12'h000) begin bad++; $display("FAIL wrap_adr got=%h want=000", adr); end
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h000) begin bad++; $display("FAIL wrap_fetch got cyc=%b adr=%h want 1/000", cyc, adr); end
    endtask

    task automatic test_redirect_with_ack();
        redirect      = 1'b1;
        redirect_addr = 12'h055;
        tick();
        redirect = 1'b0;
        total++; if (cyc !== 1'b0 || valid !== 1'b0 || adr !== 12'h055) begin bad++; $display("FAIL ra_drop got cyc=%b v=%b adr=%h want 0/0/055", cyc, valid, adr); end
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h055) begin bad++; $display("FAIL ra_fetch got cyc=%b adr=%h want 1/055", cyc, adr); end
        tick();
        total++; if (valid !== 1'b1 || inst !== 18'h0A5F0 || pc !== 12'h055) begin bad++; $display("FAIL ra_target got v=%b i=%h p=%h want 1/0a5f0/055", valid, inst, pc); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_pc [3];
        logic [17:0] exp_in [3];
        exp_pc = '{12'h056, 12'h057, 12'h058};
        exp_in = '{18'h0A5F3, 18'h0A5F2, 18'h0A5FD};
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cyc !== 1'b1 || valid !== 1'b0 || adr !== exp_pc[i]) begin bad++; $display("FAIL b2b_bus%0d got cyc=%b v=%b adr=%h want 1/0/%h", i, cyc, valid, adr, exp_pc[i]); end
            tick();
            total++; if (valid !== 1'b1 || pc !== exp_pc[i] || inst !== exp_in[i]) begin bad++; $display("FAIL b2b_inst%0d got v=%b p=%h i=%h want 1/%h/%h", i, valid, pc, inst, exp_pc[i], exp_in[i]); end
        end
    endtask

    task automatic test_reset_mid_cycle();
        ws = 3;
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h059) begin bad++; $display("FAIL rm_bus got cyc=%b adr=%h want 1/059", cyc, adr); end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mem_hold = 1'b1;
        total++; if (cyc !== 1'b0 || stb !== 1'b0 || valid !== 1'b0 || adr !== 12'h000 || pc !== 12'h000) begin bad++; $display("FAIL rm_reset got cyc=%b stb=%b v=%b adr=%h p=%h want 0/0/0/000/000", cyc, stb, valid, adr, pc); end
        tick();
        total++; if (cyc !== 1'b1 || adr !== 12'h000 || err !== 1'b0) begin bad++; $display("FAIL rm_restart got cyc=%b adr=%h err=%b want 1/000/0", cyc, adr, err); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 1; i < 15; i++) begin
            tick();
            total++; if (cyc !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL to_wait%0d got cyc=%b err=%b want 1/0", i, cyc, err); end
        end
        tick();
        total++; if (cyc !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL to_fire got cyc=%b err=%b want 0/1", cyc, err); end
        tick();
        total++; if (cyc !== 1'b1 || err !== 1'b0 || adr !== 12'h000) begin bad++; $display("FAIL to_retry got cyc=%b err=%b adr=%h want 1/0/000", cyc, err, adr); end
        mem_hold = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (cyc !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL nto_wait%0d got cyc=%b err=%b want 1/0", i, cyc, err); end
        end
        mem_hold = 1'b0;
    endtask
`endif

    initial begin
        rst           = 1'b1;
        ready         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 12'h000;
        ack           = 1'b0;
        dat           = 18'h0;
        test_reset();
        test_first_fetch();
        test_ready_stall();
        test_redirect_bus();
        test_redirect_hold_wrap();
        test_redirect_with_ack();
        test_back_to_back();
        test_reset_mid_cycle();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
